// File: rtl/reversi_pkg.sv
// Shared Reversi definitions: cell encoding, board geometry, walk
// directions with their row/column deltas, and the stage FSM states.
package reversi_pkg;

  localparam int CELL_W    = 3;
  localparam int BOARD_DIM = 8;
  localparam int NUM_CELLS = BOARD_DIM * BOARD_DIM;
  localparam int BOARD_W   = NUM_CELLS * CELL_W;

  localparam logic [CELL_W-1:0] CELL_EMPTY = 3'b000;
  localparam logic [CELL_W-1:0] CELL_WHITE = 3'b110;
  localparam logic [CELL_W-1:0] CELL_BLACK = 3'b111;

  // Walk order; also the bit order of the per-direction flip mask.
  typedef enum logic [2:0] {
    DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
  } dir_e;

  localparam logic signed [3:0] DIR_DROW [8] = '{
    -4'sd1, -4'sd1, 4'sd0, 4'sd1, 4'sd1, 4'sd1, 4'sd0, -4'sd1
  };
  localparam logic signed [3:0] DIR_DCOL [8] = '{
    4'sd0, 4'sd1, 4'sd1, 4'sd1, 4'sd0, -4'sd1, -4'sd1, -4'sd1
  };

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_WALK, ST_COMMIT, ST_DONE
  } state_e;

  // Linear cell index: row-major, cell 0 is the top-left corner.
  function automatic logic [5:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
    return {r, c};
  endfunction

endpackage

// File: rtl/flip_dir_step.sv
// One step of a board walk: moves (row, col) by the delta of dir.
// 4-bit signed arithmetic makes both 0-1 (=-1) and 7+1 (=8) show up as a
// set bit 3, so the step never silently wraps to the opposite edge.
module flip_dir_step
  import reversi_pkg::*;
(
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  dir_e       dir,
  output logic [2:0] next_row,
  output logic [2:0] next_col,
  output logic       in_range
);

  logic signed [3:0] row_s;
  logic signed [3:0] col_s;

  assign row_s    = $signed({1'b0, row}) + DIR_DROW[dir];
  assign col_s    = $signed({1'b0, col}) + DIR_DCOL[dir];
  assign next_row = row_s[2:0];
  assign next_col = col_s[2:0];
  assign in_range = ~row_s[3] & ~col_s[3];

endmodule

// File: rtl/flip_engine.sv
// Reversi flip engine: walks the 8 directions from the placed disc one cell
// per clock, collects bracketed opponent runs and rewrites them to own colour.
// Optional macro FLIP_DIR_MASK_EN adds the dir_mask output (one bit per
// direction that flipped at least one disc).
module flip_engine
  import reversi_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [BOARD_W-1:0] board_in,
  input  logic [2:0]         row,
  input  logic [2:0]         col,
  input  logic               player_black,
  output logic               busy,
  output logic               done,
  output logic [BOARD_W-1:0] board_out,
  output logic [5:0]         flip_count,
  output logic               move_valid
`ifdef FLIP_DIR_MASK_EN
  ,
  output logic [7:0]         dir_mask
`endif
);

  state_e             state_reg, state_next;
  logic [BOARD_W-1:0] work_board_reg;
  logic               own_black_reg;
  logic [2:0]         home_row_reg, home_col_reg;
  logic [2:0]         ptr_row_reg, ptr_col_reg;
  dir_e               dir_reg;
  logic [NUM_CELLS-1:0] pend_mask_reg;
  logic [2:0]         run_len_reg;
  logic               flip_hit_reg;
  logic [5:0]         acc_count_reg;

  logic [CELL_W-1:0]  own_cell, opp_cell;
  logic [CELL_W-1:0]  work_cells [NUM_CELLS];
  logic [BOARD_W-1:0] commit_board;
  logic [5:0]         commit_count;
  logic [2:0]         step_row, step_col;
  logic               step_in_range;
  logic [5:0]         step_idx;
  logic               step_is_opp, step_is_own;

  assign own_cell = own_black_reg ? CELL_BLACK : CELL_WHITE;
  assign opp_cell = own_black_reg ? CELL_WHITE : CELL_BLACK;

  flip_dir_step u_step (
    .row      (ptr_row_reg),
    .col      (ptr_col_reg),
    .dir      (dir_reg),
    .next_row (step_row),
    .next_col (step_col),
    .in_range (step_in_range)
  );

  assign step_idx    = cell_idx(step_row, step_col);
  assign step_is_opp = step_in_range && (work_cells[step_idx] == opp_cell);
  assign step_is_own = step_in_range && (work_cells[step_idx] == own_cell);

  // Per-cell view of the working board and the committed (flipped) board.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cell
      assign work_cells[gi] = work_board_reg[gi*CELL_W +: CELL_W];
      assign commit_board[gi*CELL_W +: CELL_W] =
        (flip_hit_reg && pend_mask_reg[gi]) ? own_cell : work_cells[gi];
    end
  endgenerate

  assign commit_count = acc_count_reg + (flip_hit_reg ? {3'b000, run_len_reg} : 6'd0);

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD:   state_next = ST_WALK;
      ST_WALK:   if (!step_is_opp) state_next = ST_COMMIT;
      ST_COMMIT: state_next = (dir_reg == DIR_NW) ? ST_DONE : ST_WALK;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  // Walk datapath: latch request, step pointer, gather runs, commit flips.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      work_board_reg <= '0;
      own_black_reg  <= 1'b0;
      home_row_reg   <= '0;
      home_col_reg   <= '0;
      ptr_row_reg    <= '0;
      ptr_col_reg    <= '0;
      dir_reg        <= DIR_N;
      pend_mask_reg  <= '0;
      run_len_reg    <= '0;
      flip_hit_reg   <= 1'b0;
      acc_count_reg  <= '0;
      board_out      <= '0;
      flip_count     <= '0;
      move_valid     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            work_board_reg <= board_in;
            own_black_reg  <= player_black;
            home_row_reg   <= row;
            home_col_reg   <= col;
            pend_mask_reg  <= '0;
            run_len_reg    <= '0;
            flip_hit_reg   <= 1'b0;
            acc_count_reg  <= '0;
          end
        end
        ST_LOAD: begin
          dir_reg     <= DIR_N;
          ptr_row_reg <= home_row_reg;
          ptr_col_reg <= home_col_reg;
        end
        ST_WALK: begin
          ptr_row_reg <= step_row;
          ptr_col_reg <= step_col;
          if (step_is_opp) begin
            pend_mask_reg[step_idx] <= 1'b1;
            run_len_reg             <= run_len_reg + 3'd1;
          end else begin
            flip_hit_reg <= step_is_own && (run_len_reg != 3'd0);
          end
        end
        ST_COMMIT: begin
          work_board_reg <= commit_board;
          acc_count_reg  <= commit_count;
          pend_mask_reg  <= '0;
          run_len_reg    <= '0;
          flip_hit_reg   <= 1'b0;
          ptr_row_reg    <= home_row_reg;
          ptr_col_reg    <= home_col_reg;
          if (dir_reg != DIR_NW) begin
            dir_reg <= dir_e'(dir_reg + 3'd1);
          end else begin
            // Results become visible together with the done pulse.
            board_out  <= commit_board;
            flip_count <= commit_count;
            move_valid <= (commit_count != 6'd0);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FLIP_DIR_MASK_EN
  logic [7:0] dir_acc_reg;
  logic [7:0] dir_bit;

  assign dir_bit = flip_hit_reg ? (8'd1 << dir_reg) : 8'd0;

  // Accumulate which directions flipped; publish alongside the other results.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dir_acc_reg <= '0;
      dir_mask    <= '0;
    end else if (state_reg == ST_IDLE && start) begin
      dir_acc_reg <= '0;
    end else if (state_reg == ST_COMMIT) begin
      dir_acc_reg <= dir_acc_reg | dir_bit;
      if (dir_reg == DIR_NW) dir_mask <= dir_acc_reg | dir_bit;
    end
  end
`endif

endmodule
